// File: rtl/keccak_perm_pkg.sv
// Shared constants, state encoding and index maps for the Keccak pi/rho line permutations.
package keccak_perm_pkg;

  localparam int LINES = 64;
  localparam int WIDTH = 25;
  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] CNT_BASE = 7'd63;
  localparam logic [CNT_W-1:0] CNT_LAST = 7'd126;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT_HI,
    ST_EMIT_LO,
    ST_DONE
  } state_t;

  // Rho offsets indexed by line bit b = 5*y + x
  localparam logic [WIDTH-1:0][5:0] RHO_TBL = {
    6'd14, 6'd56, 6'd61, 6'd2,  6'd18,
    6'd8,  6'd21, 6'd15, 6'd45, 6'd41,
    6'd39, 6'd25, 6'd43, 6'd10, 6'd3,
    6'd20, 6'd55, 6'd6,  6'd44, 6'd36,
    6'd27, 6'd28, 6'd62, 6'd1,  6'd0
  };

  function automatic logic [5:0] rho_off(input int x, input int y);
    return RHO_TBL[5*y + x];
  endfunction

  // Forward pi: output bit (x,y) is taken from this input bit index.
  function automatic int pi_idx(input int x, input int y);
    return 5*x + ((x + 3*y) % 5);
  endfunction

  // Inverse pi: output bit (x,y) is taken from this input bit index.
  function automatic int invpi_idx(input int x, input int y);
    return 5*((2*x + 3*y) % 5) + y;
  endfunction

  function automatic logic [WIDTH-1:0] invpi(input logic [WIDTH-1:0] l);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[5*y + x] = l[invpi_idx(x, y)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_rho_slice_mux.sv
// Inverse rho for one output line: each bit lane picks its slice from the buffer
// at (z + offset) with natural 6-bit wrap.
module inv_rho_slice_mux
  import keccak_perm_pkg::*;
(
  input  logic [LINES-1:0][WIDTH-1:0] i_buf,
  input  logic [5:0]                  i_z,
  output logic [WIDTH-1:0]            o_line
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [5:0] w_src;
    assign w_src     = i_z + rho_off(b % 5, b / 5);
    assign o_line[b] = i_buf[w_src][b];
  end

endmodule

// File: rtl/inverse_permutation_func.sv
// Keccak inverse pi + inverse rho over 64 fetched lines, emitted one line per two cycles.
//   state   | meaning
//   IDLE    | waiting for start, cnt_value parked at base
//   LOAD    | fetch 64 lines, store inverse-pi of each
//   EMIT_HI | register line z, raise write_enable
//   EMIT_LO | drop write_enable, advance z
//   DONE    | donee raised; leave when start is low
module inverse_permutation_func
  import keccak_perm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] line_in,
  output logic [CNT_W-1:0] cnt_value,
  output logic             write_enable,
  output logic [WIDTH-1:0] write_value,
  output logic             donee
);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic [5:0]                  r_z;
  logic                        r_we;
  logic [WIDTH-1:0]            r_wv;
  logic                        r_donee;
  logic [LINES-1:0][WIDTH-1:0] r_buf;
  logic [5:0]                  w_addr;
  logic [WIDTH-1:0]            w_line;

  assign w_addr = 6'(r_cnt - CNT_BASE);

  inv_rho_slice_mux u_inv_rho (
    .i_buf  (r_buf),
    .i_z    (r_z),
    .o_line (w_line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_LOAD;
      ST_LOAD:    if (r_cnt == CNT_LAST) w_state_nxt = ST_EMIT_HI;
      ST_EMIT_HI: w_state_nxt = ST_EMIT_LO;
      ST_EMIT_LO: w_state_nxt = (r_z == 6'd63) ? ST_DONE : ST_EMIT_HI;
      // donee must be seen high for a cycle before start can release the block
      ST_DONE:    if (r_donee && !start) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= CNT_BASE;
      r_z     <= '0;
      r_we    <= 1'b0;
      r_wv    <= '0;
      r_donee <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt   <= CNT_BASE;
          r_donee <= 1'b0;
        end
        ST_LOAD: begin
          r_cnt <= (r_cnt == CNT_LAST) ? CNT_BASE : r_cnt + 7'd1;
          r_z   <= '0;
        end
        ST_EMIT_HI: begin
          r_we <= 1'b1;
          r_wv <= w_line;
        end
        ST_EMIT_LO: begin
          r_we <= 1'b0;
          r_z  <= r_z + 6'd1;
        end
        ST_DONE: begin
          if (!r_donee)   r_donee <= 1'b1;
          else if (!start) r_donee <= 1'b0;
        end
        default: r_cnt <= CNT_BASE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) r_buf[w_addr] <= invpi(line_in);
  end

  assign cnt_value    = r_cnt;
  assign write_enable = r_we;
  assign write_value  = r_wv;
  assign donee        = r_donee;

endmodule

// File: tb/tb_inverse_permutation_func.sv
// Checks inverse_permutation_func with directed vectors, a coordinate-level model and forward/inverse round trips.
module tb_inverse_permutation_func;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [24:0] line_in;
  logic [6:0]  cnt_value;
  logic        write_enable;
  logic [24:0] write_value;
  logic        donee;

  logic [24:0] mem [64];
  logic [24:0] orig [64];
  logic [24:0] exp_l [64];
  logic [24:0] outq [$];
  logic [5:0]  rd_idx;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int first_we_edge = -1;
  int done_edge = -1;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;

  int rho_tb [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                      41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  typedef struct {
    logic [24:0] fill;
    int          in_line;
    logic [24:0] in_val;
    logic [24:0] exp_fill;
    int          exp_line;
    logic [24:0] exp_val;
  } vec_t;
  vec_t tab [6];

  inverse_permutation_func dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .line_in      (line_in),
    .cnt_value    (cnt_value),
    .write_enable (write_enable),
    .write_value  (write_value),
    .donee        (donee)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  assign rd_idx  = 6'(cnt_value - 7'd63);
  assign line_in = mem[rd_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (write_enable && !prev_we) begin
      if (outq.size() == 0) first_we_edge = edge_cnt;
      outq.push_back(write_value);
    end
    if (!write_enable && prev_we && !rst && outq.size() > 0)
      chk("hold_low_cycle", write_value, outq[outq.size()-1]);
    if (donee && !prev_done) done_edge = edge_cnt;
    prev_we   = write_enable;
    prev_done = donee;
  end

  // out[z] bit (x,y) = in[(z + R(x,y)) mod 64] bit at the inverse-pi source of (x,y)
  task automatic model_inverse();
    for (int z = 0; z < 64; z++) begin
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 5; x++) begin
          int src_line = (z + rho_tb[5*y + x]) % 64;
          int src_bit  = 5*((2*x + 3*y) % 5) + y;
          exp_l[z][5*y + x] = mem[src_line][src_bit];
        end
      end
    end
  endtask

  // forward permutation: rho (lane rotate) then pi, applied to orig into mem
  task automatic encode_forward();
    for (int z = 0; z < 64; z++) begin
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 5; x++) begin
          int xs = (x + 3*y) % 5;
          int ys = x;
          int sl = (z + 64 - rho_tb[5*ys + xs]) % 64;
          mem[z][5*y + x] = orig[sl][5*ys + xs];
        end
      end
    end
  endtask

  task automatic run_op(input int drop_after);
    int e;
    int n;
    outq.delete();
    first_we_edge = -1;
    done_edge = -1;
    @(negedge clk);
    start = 1'b1;
    e = edge_cnt + 1;
    n = 0;
    while (!donee && n < 400) begin
      @(negedge clk);
      n++;
      if (n == drop_after) start = 1'b0;
    end
    #1;
    chk("donee_rise", donee, 1);
    chk("we_pulses", outq.size(), 64);
    chk("first_we_edge", first_we_edge - e, 65);
    chk("done_edge", done_edge - e, 193);
  endtask

  task automatic finish_op();
    start = 1'b0;
    @(negedge clk);
    chk("donee_clear", donee, 0);
  endtask

  task automatic cmp_out(input string tag);
    if (outq.size() != 64) begin
      chk({tag, "_count"}, outq.size(), 64);
    end else begin
      for (int z = 0; z < 64; z++) chk($sformatf("%s[%0d]", tag, z), outq[z], exp_l[z]);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"}, cnt_value, 7'd63);
    chk({tag, "_we"}, write_enable, 0);
    chk({tag, "_wv"}, write_value, 0);
    chk({tag, "_donee"}, donee, 0);
  endtask

  task automatic abort_and_idle(input string tag);
    #2 rst = 1'b1;
    #1 chk_reset_vals(tag);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    outq.delete();
    repeat (200) @(negedge clk);
    chk({tag, "_no_we"}, outq.size(), 0);
    chk({tag, "_no_done"}, donee, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    #1 chk_reset_vals("reset");
    #20;
    @(negedge clk);
    rst = 1'b0;

    tab[0] = '{25'h0, 5, 25'h0000400, 25'h0, 4, 25'h0000002};
    tab[1] = '{25'h0, 0, 25'h0000001, 25'h0, 0, 25'h0000001};
    tab[2] = '{25'h0, 0, 25'h0000002, 25'h0, 20, 25'h0000040};
    tab[3] = '{25'h0, 10, 25'h1000000, 25'h0, 8, 25'h0200000};
    tab[4] = '{25'h1FFFFFF, 0, 25'h1FFFFFF, 25'h1FFFFFF, 0, 25'h1FFFFFF};
    tab[5] = '{25'h0, 0, 25'h0, 25'h0, 0, 25'h0};

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 64; i++) mem[i] = tab[t].fill;
      mem[tab[t].in_line] = tab[t].in_val;
      for (int i = 0; i < 64; i++) exp_l[i] = tab[t].exp_fill;
      exp_l[tab[t].exp_line] = tab[t].exp_val;
      run_op((t == 0) ? 3 : 0);
      cmp_out($sformatf("vec%0d", t));
      finish_op();
    end

    for (int r = 0; r < 4; r++) begin
      fill_random();
      model_inverse();
      run_op(0);
      cmp_out($sformatf("rand%0d", r));
      finish_op();
    end

    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < 64; i++) orig[i] = 25'($urandom);
      encode_forward();
      for (int i = 0; i < 64; i++) exp_l[i] = orig[i];
      run_op(0);
      cmp_out($sformatf("roundtrip%0d", s));
      finish_op();
    end

    // start held through DONE: no rerun, donee stays high
    fill_random();
    model_inverse();
    run_op(0);
    repeat (30) @(negedge clk);
    chk("held_donee", donee, 1);
    chk("held_no_rerun", outq.size(), 64);
    chk("held_cnt_idle", cnt_value, 7'd63);
    finish_op();
    fill_random();
    model_inverse();
    run_op(0);
    cmp_out("restart");
    finish_op();

    // abort during LOAD
    fill_random();
    @(negedge clk);
    start = 1'b1;
    repeat (30) @(negedge clk);
    abort_and_idle("rst_load");
    model_inverse();
    run_op(0);
    cmp_out("after_rst_load");
    finish_op();

    // abort during EMIT at line 20
    fill_random();
    outq.delete();
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (outq.size() < 20 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_line20", outq.size(), 20);
    abort_and_idle("rst_emit");
    model_inverse();
    run_op(0);
    cmp_out("after_rst_emit");
    finish_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
